// File: rtl/mem_pkg.sv
// Shared types and default sizes for the MAR/MDR memory responder.
package mem_pkg;

  localparam int MEM_ADDR_WIDTH = 9;
  localparam int MEM_DATA_WIDTH = 32;
  localparam int MEM_DEPTH      = 512;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } state_e;

  // Counter must hold WAIT_CYCLES itself; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM; read data is registered only when re is high,
// so rdata holds the last value read.
module mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 512,
  parameter int IDX_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  re,
  input  logic                  we,
  input  logic [IDX_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Contents survive reset.
  always_ff @(posedge clock) begin
    if (we) mem_q[addr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset)   rdata_q <= '0;
    else if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one access at a time, fixed wait, one-cycle done pulse.
// Optional MEM_BOUNDS_CHECK_EN flags addresses >= DEPTH instead of wrapping them.
//
// state | meaning
// IDLE  | waiting for read/write strobe (write wins)
// WAIT  | counting down WAIT_CYCLES with latched request
// DONE  | done pulse; read data valid, write commits on exit
// HOLD  | waiting for both strobes low before re-arming
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH  = MEM_DATA_WIDTH,
  parameter int DEPTH       = MEM_DEPTH,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  done,
  output logic                  busy,
  output logic                  error
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = cnt_width(WAIT_CYCLES);

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [IW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  op_wr_q;
  logic                  oob_q;
  logic                  done_q;
  logic                  busy_q;
  logic                  err_q;
  logic                  rd_zero_q;

  logic                  accept;
  logic                  oob_d;
  logic [IW-1:0]         idx_d;
  logic                  enter_done;
  logic                  rd_op_cur;
  logic                  oob_cur;
  logic                  ram_re;
  logic                  ram_we;
  logic [IW-1:0]         ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign accept = (state_q == IDLE) && (read || write);
  assign idx_d  = address[IW-1:0];

`ifdef MEM_BOUNDS_CHECK_EN
  assign oob_d = 32'(address) >= 32'(DEPTH);
`else
  assign oob_d = 1'b0;
`endif

  // With no wait the read must be issued on the acceptance edge itself,
  // so in IDLE the RAM sees the live address and strobe.
  assign enter_done = (accept && (WAIT_CYCLES == 0)) ||
                      ((state_q == WAIT) && (cnt_q == CW'(1)));
  assign rd_op_cur  = (state_q == IDLE) ? !write : !op_wr_q;
  assign oob_cur    = (state_q == IDLE) ? oob_d : oob_q;
  assign ram_addr   = (state_q == IDLE) ? idx_d : idx_q;
  assign ram_re     = enter_done && rd_op_cur && !oob_cur && !reset;
  assign ram_we     = (state_q == DONE) && op_wr_q && !oob_q && !reset;

  mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_WIDTH  (IW)
  ) u_mem_array (
    .clock (clock),
    .reset (reset),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      op_wr_q   <= 1'b0;
      oob_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (enter_done) begin
        done_q <= 1'b1;
        err_q  <= oob_cur;
        if (rd_op_cur) rd_zero_q <= oob_cur;
      end
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            idx_q   <= idx_d;
            wdata_q <= data_in;
            op_wr_q <= write;
            oob_q   <= oob_d;
            cnt_q   <= CW'(WAIT_CYCLES);
            busy_q  <= 1'b1;
            state_q <= (WAIT_CYCLES == 0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= DONE;
        end
        DONE: state_q <= HOLD;
        HOLD: begin
          if (!read && !write) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // err_q can only be set when bounds checking is compiled in.
  assign data_out = rd_zero_q ? '0 : ram_rdata;
  assign done     = done_q;
  assign busy     = busy_q;
  assign error    = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a scoreboard of expected completions.
// Two instances: A (WAIT_CYCLES=2) and B (WAIT_CYCLES=0), both DEPTH=256.
module tb_mem_responder;

`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, read, write, sel;
  logic [8:0]  address;
  logic [31:0] data_in;

  logic        rd_a, wr_a, rd_b, wr_b;
  logic [31:0] dout_a, dout_b;
  logic        done_a, done_b, busy_a, busy_b, err_a, err_b;

  assign rd_a = read & ~sel;
  assign wr_a = write & ~sel;
  assign rd_b = read & sel;
  assign wr_b = write & sel;

  mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .DEPTH(256), .WAIT_CYCLES(2)) u_dut_a (
    .clock(clock), .reset(reset), .read(rd_a), .write(wr_a), .address(address),
    .data_in(data_in), .data_out(dout_a), .done(done_a), .busy(busy_a), .error(err_a)
  );

  mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .DEPTH(256), .WAIT_CYCLES(0)) u_dut_b (
    .clock(clock), .reset(reset), .read(rd_b), .write(wr_b), .address(address),
    .data_in(data_in), .data_out(dout_b), .done(done_b), .busy(busy_b), .error(err_b)
  );

  logic [31:0] o_dout;
  logic        o_done, o_busy, o_err;
  assign o_dout = sel ? dout_b : dout_a;
  assign o_done = sel ? done_b : done_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_err  = sel ? err_b  : err_a;

  typedef struct {
    logic [31:0] dout;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [int];
  logic [31:0] last_rd [2];
  int          tests, fails;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_oob(input logic [8:0] a);
    return BOUNDS && (a >= 9'd256);
  endfunction

  function automatic int key(input logic [8:0] a);
    return (sel ? 1024 : 0) + int'(a[7:0]);
  endfunction

  function automatic int wait_cycles();
    return sel ? 0 : 2;
  endfunction

  // Drive a request (at a falling edge) and record what its completion must show.
  task automatic issue(input logic do_rd, input logic do_wr, input logic [8:0] a,
                       input logic [31:0] d);
    exp_t e;
    e.err = is_oob(a);
    if (do_wr) begin
      if (!is_oob(a)) model[key(a)] = d;
      e.dout = last_rd[sel];
    end else begin
      e.dout = is_oob(a) ? 32'h0 : model[key(a)];
      last_rd[sel] = e.dout;
    end
    sb.push_back(e);
    read    = do_rd;
    write   = do_wr;
    address = a;
    data_in = d;
  endtask

  // pre = rising edges already consumed since the request was driven.
  task automatic finish_access(input string tag, input int pre);
    int   n = pre;
    bit   seen = 1'b0;
    exp_t e;
    while (n < 20 && !seen) begin
      @(posedge clock); n++;
      @(negedge clock); seen = o_done;
    end
    if (!seen) begin
      tests++; fails++;
      $error("FAIL %s_timeout: observed no done after %0d edges, required done", tag, n);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      chk({tag, "_lat"}, n, wait_cycles() + 1);
      e = sb.pop_front();
      chk({tag, "_err"}, {31'h0, o_err}, {31'h0, e.err});
      chk({tag, "_dout"}, o_dout, e.dout);
    end
    read  = 1'b0;
    write = 1'b0;
    @(posedge clock); @(negedge clock);
    chk({tag, "_hold_busy"}, {31'h0, o_busy}, 32'h1);
    chk({tag, "_hold_done"}, {31'h0, o_done}, 32'h0);
    @(posedge clock); @(negedge clock);
    chk({tag, "_idle_busy"}, {31'h0, o_busy}, 32'h0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    read  = 1'b0;
    write = 1'b0;
    @(posedge clock); @(negedge clock);
    reset = 1'b0;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
  endtask

  initial begin
    int n;
    int cnt;
    int first;
    bit seen;
    exp_t e;

    tests = 0; fails = 0;
    reset = 1'b1; read = 1'b0; write = 1'b0; sel = 1'b0;
    address = '0; data_in = '0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rst_busy", {31'h0, o_busy}, 32'h0);
    chk("rst_done", {31'h0, o_done}, 32'h0);
    chk("rst_dout", o_dout, 32'h0);
    chk("rst_err",  {31'h0, o_err}, 32'h0);

    issue(1'b0, 1'b1, 9'h010, 32'hDEADBEEF); finish_access("wr010", 0);
    issue(1'b1, 1'b0, 9'h010, 32'h0);        finish_access("rd010", 0);

    issue(1'b1, 1'b1, 9'h020, 32'h12345678); finish_access("both020", 0);
    issue(1'b1, 1'b0, 9'h020, 32'h0);        finish_access("rd020", 0);

    // Abort a write in WAIT.
    issue(1'b0, 1'b1, 9'h030, 32'h11112222); finish_access("wr030", 0);
    address = 9'h030; data_in = 32'hCAFEF00D; write = 1'b1;
    @(posedge clock); @(negedge clock);
    chk("abort_busy_pre", {31'h0, o_busy}, 32'h1);
    @(posedge clock); @(negedge clock);
    pulse_reset();
    chk("abort_busy", {31'h0, o_busy}, 32'h0);
    chk("abort_done", {31'h0, o_done}, 32'h0);
    chk("abort_dout", o_dout, 32'h0);
    issue(1'b1, 1'b0, 9'h030, 32'h0); finish_access("rd030_abort", 0);

    // Reset landing on the DONE cycle must still block the commit.
    address = 9'h030; data_in = 32'h55555555; write = 1'b1;
    n = 0; seen = 1'b0;
    while (n < 20 && !seen) begin
      @(posedge clock); n++;
      @(negedge clock); seen = o_done;
    end
    if (!seen) begin
      tests++; fails++;
      $error("FAIL rstdone_timeout: observed no done, required done");
    end
    pulse_reset();
    chk("rstdone_busy", {31'h0, o_busy}, 32'h0);
    issue(1'b1, 1'b0, 9'h030, 32'h0); finish_access("rd030_rstdone", 0);

    // Inputs changed during WAIT are ignored.
    issue(1'b0, 1'b1, 9'h041, 32'h0); finish_access("wr041", 0);
    issue(1'b0, 1'b1, 9'h040, 32'hA5A5A5A5);
    @(posedge clock); @(negedge clock);
    address = 9'h041; data_in = 32'h5A5A5A5A;
    finish_access("wr040_latched", 1);
    issue(1'b1, 1'b0, 9'h040, 32'h0); finish_access("rd040", 0);
    issue(1'b1, 1'b0, 9'h041, 32'h0); finish_access("rd041", 0);

    // Address beyond DEPTH: wraps, or flags error when bounds checking is built in.
    issue(1'b0, 1'b1, 9'h0FF, 32'h0F0F0F0F); finish_access("wr0ff", 0);
    issue(1'b0, 1'b1, 9'h1FF, 32'h0BADF00D); finish_access("wr1ff", 0);
    issue(1'b1, 1'b0, 9'h0FF, 32'h0);        finish_access("rd0ff", 0);
    issue(1'b1, 1'b0, 9'h1FF, 32'h0);        finish_access("rd1ff", 0);

    // Zero-wait instance: a held read completes exactly once.
    sel = 1'b1;
    issue(1'b0, 1'b1, 9'h005, 32'h77778888); finish_access("b_wr005", 0);
    issue(1'b1, 1'b0, 9'h005, 32'h0);
    cnt = 0; first = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clock); @(negedge clock);
      if (o_done) begin
        cnt++;
        if (first == 0) first = i;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("b_held_dout", o_dout, e.dout);
        end
      end
    end
    chk("b_held_done_count", cnt, 1);
    chk("b_held_first_edge", first, 1);
    chk("b_held_busy", {31'h0, o_busy}, 32'h1);
    read = 1'b0;
    @(posedge clock); @(negedge clock);
    chk("b_release_busy", {31'h0, o_busy}, 32'h0);
    chk("b_release_done", {31'h0, o_done}, 32'h0);
    issue(1'b1, 1'b0, 9'h005, 32'h0); finish_access("b_rd005_again", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
